reg_file_wb_arbiter: RTL and testbench
======================================

Name: reg_file_wb_arbiter

Overview:
- Shares the single register-file write port (write_enable / address_d / data_dval) between two writeback requesters: ALU result path and memory-load path.
- Keeps a per-register pending scoreboard so the hazard logic can stall readers of in-flight destinations.
- Sits between the execute/memory stages and reg_file; its write outputs connect directly to reg_file's write inputs.

Parameters:
- data_width, 32, width of writeback data.
- address_width, 5, register address width.
- reg_depth, 32, number of registers (2**address_width).
- STARVE_LIMIT, 4, consecutive ALU losses before the ALU is forced to win.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  address_width  ALU destination register
- alu_data  input  data_width  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  load request accepted this cycle
- mem_addr  input  address_width  load destination register
- mem_data  input  data_width  load data
- issue_valid  input  1  an instruction with a destination issues this cycle
- issue_addr  input  address_width  destination of the issuing instruction
- write_enable  output  1  to reg_file write enable
- address_d  output  address_width  to reg_file write address
- data_dval  output  data_width  to reg_file write data
- pending  output  reg_depth  bit i = register i awaiting writeback

Behaviour:
- Reset (reset==0 at a rising edge):
  - write_enable=0, address_d=0, data_dval=0.
  - pending=0; starvation counter=0.
  - alu_ready and mem_ready are forced 0 while reset==0.
- Handshake:
  - A transfer occurs when valid && ready.
  - ready is combinational from arbitration; at most one ready is high per cycle.
  - A requester holds valid, addr and data stable until its transfer completes.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: mem wins, unless the starvation counter == STARVE_LIMIT, in which case alu wins.
  - Neither valid: both readies are 0.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on a cycle with alu_valid && !alu_ready.
  - Clears to 0 on an ALU transfer or when alu_valid==0.
- Write port timing:
  - Registered outputs; latency is one cycle.
  - A transfer at edge N drives write_enable=1, address_d=addr and data_dval=data for cycle N+1.
  - With no transfer, write_enable=0 and address_d/data_dval hold their last values.
- Register 0:
  - A transfer with addr==0 is accepted (ready asserted normally).
  - write_enable stays 0 for that cycle; address_d and data_dval still update.
- Scoreboard:
  - issue_valid with issue_addr!=0 sets pending[issue_addr] at the edge.
  - A transfer clears pending[addr] at the same edge the write is registered.
  - Set and clear on the same address in the same cycle: set wins, because a newer producer is in flight.
  - pending[0] is always 0.
  - A transfer to a non-pending register is legal and leaves pending unchanged.
- Reset mid-operation: in-flight writes are discarded; on the edge after reset, no write_enable pulse issues for requests granted before reset.

Optional Feature:
- Macro WB_ROUND_ROBIN_EN.
- Defined:
  - When both requesters are valid, the grant alternates using a last-grant pointer.
  - Reset state favours mem first.
  - The pointer updates only on a contended transfer.
  - The starvation counter and STARVE_LIMIT have no effect.
- Undefined: fixed mem priority with the starvation override described above.

Test Plan:
- Reset: reset=0 for 3 cycles with alu_valid=mem_valid=1 -> readies 0, write_enable 0, pending all 0.
- ALU only: alu_addr=5, alu_data=0xA5 for 1 cycle -> alu_ready=1; next cycle write_enable=1, address_d=5, data_dval=0xA5; reg_file reads 0xA5 from register 5 afterwards.
- Contention, STARVE_LIMIT=4, macro off: both valid continuously -> mem granted cycles 1-4, alu granted cycle 5, counter returns to 0, mem granted cycle 6.
- Register 0: mem_addr=0, mem_data=0xFFFF -> mem_ready=1, write_enable stays 0; register 0 reads 0.
- Scoreboard: issue addr 7 -> pending[7]=1 next cycle; mem write to 7 -> pending[7]=0 after transfer; issue 7 and ALU transfer to 7 in the same cycle -> pending[7] stays 1.
- Mid-operation reset and round-robin: reset=0 during an accepted transfer -> no write_enable pulse follows. With WB_ROUND_ROBIN_EN, both valid for 4 cycles -> grants mem, alu, mem, alu.

Source files
------------

// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter: shares the reg_file write port between ALU and load writeback and tracks pending destinations.
// Define WB_ROUND_ROBIN_EN to replace mem priority plus ALU starvation override with round-robin on contention.
module reg_file_wb_arbiter #(
  parameter int data_width    = 32,
  parameter int address_width = 5,
  parameter int reg_depth     = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [address_width-1:0] alu_addr,
  input  logic [data_width-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [address_width-1:0] mem_addr,
  input  logic [data_width-1:0]    mem_data,
  input  logic                     issue_valid,
  input  logic [address_width-1:0] issue_addr,
  output logic                     write_enable,
  output logic [address_width-1:0] address_d,
  output logic [data_width-1:0]    data_dval,
  output logic [reg_depth-1:0]     pending
);
  localparam int cw = $clog2(STARVE_LIMIT + 1);
  logic [cw-1:0]            starve_q, starve_d;
  logic                     wr_en_q, wr_en_d;
  logic [address_width-1:0] wr_addr_q, wr_addr_d;
  logic [data_width-1:0]    wr_data_q, wr_data_d;
  logic [reg_depth-1:0]     pending_q, pending_d;
  logic                     alu_pri, xfer;
  logic [address_width-1:0] sel_addr;
  logic [data_width-1:0]    sel_data;
  logic [reg_depth-1:0]     set_mask, clr_mask;
`ifdef WB_ROUND_ROBIN_EN
  logic last_alu_q, last_alu_d;
  assign alu_pri = !last_alu_q;
`else
  assign alu_pri = starve_q == cw'(STARVE_LIMIT);
`endif
  always_comb begin
    alu_ready = reset && alu_valid && (!mem_valid || alu_pri);
    mem_ready = reset && mem_valid && !alu_ready;
    xfer      = alu_ready || mem_ready;
    sel_addr  = alu_ready ? alu_addr : mem_addr;
    sel_data  = alu_ready ? alu_data : mem_data;
    starve_d  = (!alu_valid || alu_ready) ? '0 :
                (starve_q == cw'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    // Register 0 is hardwired: accept the transfer but never pulse the write.
    wr_en_d   = xfer && (sel_addr != '0);
    wr_addr_d = xfer ? sel_addr : wr_addr_q;
    wr_data_d = xfer ? sel_data : wr_data_q;
    clr_mask  = xfer ? reg_depth'(1) << sel_addr : '0;
    set_mask  = issue_valid ? reg_depth'(1) << issue_addr : '0;
    // Set applied after clear so a newer in-flight producer keeps its bit.
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~reg_depth'(1);
  end
`ifdef WB_ROUND_ROBIN_EN
  assign last_alu_d = (alu_valid && mem_valid && xfer) ? alu_ready : last_alu_q;
  always_ff @(posedge clock) begin
    if (!reset) last_alu_q <= 1'b1;
    else        last_alu_q <= last_alu_d;
  end
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end
  assign write_enable = wr_en_q;
  assign address_d    = wr_addr_q;
  assign data_dval    = wr_data_q;
  assign pending      = pending_q;
endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// tb_reg_file_wb_arbiter: directed vector table plus a mid-operation reset sequence for reg_file_wb_arbiter.
module tb_reg_file_wb_arbiter;
  logic        clock, reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, issue_valid, write_enable;
  logic [4:0]  alu_addr, mem_addr, issue_addr, address_d;
  logic [31:0] alu_data, mem_data, data_dval, pending;
  logic [31:0] rf [32];
  int n_checks = 0;
  int n_fail = 0;
`ifdef WB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  reg_file_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .write_enable(write_enable), .address_d(address_d), .data_dval(data_dval), .pending(pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (write_enable) rf[address_d] <= data_dval;
  end

  typedef struct {
    logic rst_n; logic av; logic [4:0] aa; logic [31:0] ad;
    logic mv; logic [4:0] ma; logic [31:0] md; logic iv; logic [4:0] ia;
    logic e_ar; logic e_mr; logic e_we; logic [4:0] e_addr; logic [31:0] e_data; logic [31:0] e_pend;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic av, logic [4:0] aa, logic [31:0] ad,
                              logic mv, logic [4:0] ma, logic [31:0] md, logic iv, logic [4:0] ia,
                              logic e_ar, logic e_mr, logic e_we, logic [4:0] e_addr,
                              logic [31:0] e_data, logic [31:0] e_pend);
    vec_t v;
    v.rst_n = rst_n; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.iv = iv; v.ia = ia; v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we;
    v.e_addr = e_addr; v.e_data = e_data; v.e_pend = e_pend;
    return v;
  endfunction

  // Both requesters valid: ALU writes r1=0x100, mem writes r2=0x200.
  function automatic vec_t cont(logic alu_win, logic [31:0] pend);
    return mk(1, 1, 1, 32'h100, 1, 2, 32'h200, 0, 0,
              alu_win, !alu_win, 1, alu_win ? 5'd1 : 5'd2, alu_win ? 32'h100 : 32'h200, pend);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset = v.rst_n; alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md; issue_valid = v.iv; issue_addr = v.ia;
    #3;
    chk("alu_ready", idx, 32'(alu_ready), 32'(v.e_ar));
    chk("mem_ready", idx, 32'(mem_ready), 32'(v.e_mr));
    @(posedge clock);
    #1;
    chk("write_enable", idx, 32'(write_enable), 32'(v.e_we));
    chk("address_d", idx, 32'(address_d), 32'(v.e_addr));
    chk("data_dval", idx, data_dval, v.e_data);
    chk("pending", idx, pending, v.e_pend);
  endtask

  initial begin
    vec_t vecs[$];
    logic [5:0] w1;
    logic [2:0] w2;
    logic [4:0] w3;
    w1 = RR ? 6'b101010 : 6'b010000;
    w2 = RR ? 3'b010 : 3'b000;
    w3 = RR ? 5'b10101 : 5'b10000;
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 3, 32'h1, 1, 4, 32'h2, 1, 9, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 32'hA5, 0, 0, 0, 0, 0, 1, 0, 1, 5, 32'hA5, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hA5, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5, 32'hA5, 32'h80));
    vecs.push_back(mk(1, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 1, 7, 32'h77, 0));
    vecs.push_back(mk(1, 1, 7, 32'h11, 0, 0, 0, 1, 7, 1, 0, 1, 7, 32'h11, 32'h80));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 32'hFFFF, 32'h80));
    for (int k = 0; k < 6; k++) vecs.push_back(cont(w1[k], 32'h80));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, w1[5] ? 5'd1 : 5'd2,
                      w1[5] ? 32'h100 : 32'h200, 32'h80));
    vecs.push_back(mk(1, 0, 0, 0, 1, 7, 32'h7, 1, 3, 0, 1, 1, 7, 32'h7, 32'h8));
    for (int k = 0; k < 3; k++) vecs.push_back(cont(w2[k], 32'h8));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 32'h200, 0, 0, 0, 1, 1, 2, 32'h200, 32'h8));
    for (int k = 0; k < 5; k++) vecs.push_back(cont(w3[k], 32'h8));

    reset = 0; alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_addr = 0; mem_addr = 0; issue_addr = 0; alu_data = 0; mem_data = 0;
    @(posedge clock);
    #1;
    foreach (vecs[i]) begin
      apply(vecs[i], i);
      if (i == 4) chk("rf_r5", i, rf[5], 32'hA5);
      if (i == 8) chk("rf_r0", i, rf[0], 32'h0);
    end

    // Accepted transfer followed by reset: the write and pending bits are dropped.
    apply(mk(1, 1, 9, 32'h99, 0, 0, 0, 1, 12, 1, 0, 1, 9, 32'h99, 32'h1008), 100);
    apply(mk(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101);
    apply(cont(0, 0), 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
